seq_array_multiplier: RTL and testbench

Parametrised sequential shift-add multiplier: the multi-cycle successor to the combinational 4×4 AND/full-adder array multiplier. It multiplies two WIDTH-bit operands, unsigned or two's-complement (selected per operation), using one conditional-add row per clock. It exposes a start/busy/done handshake and holds the 2·WIDTH-bit product until the next operation. It sits behind the Tiny Tapeout pin wrapper; the wrapper maps ui_in to the operands and uo_out to the product.

---
 rtl/seq_mult_pkg.sv | 18 +
 rtl/mult_add_row.sv | 25 ++
 rtl/seq_array_multiplier.sv | 125 ++++++++++++
 tb/tb_seq_array_multiplier.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/seq_mult_pkg.sv
// Shared types and constants for the sequential shift-add multiplier.
package seq_mult_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StFix
  } state_e;

  localparam int unsigned WidthMin = 2;
  localparam int unsigned WidthMax = 16;

  // Bits needed to index one multiplier bit, never less than one.
  function automatic int unsigned cnt_width(input int unsigned width);
    return (width <= 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/mult_add_row.sv
// One conditional-add row: partial-product AND gates feeding a ripple full-adder chain.
module mult_add_row #(
  parameter int unsigned WIDTH = 4
) (
  input  logic [WIDTH-1:0] i_acc_hi,
  input  logic [WIDTH-1:0] i_mag_a,
  input  logic             i_b_bit,
  output logic [WIDTH-1:0] o_sum,
  output logic             o_carry
);

  logic [WIDTH-1:0] w_pp;
  logic [WIDTH:0]   w_c;

  assign w_pp   = i_mag_a & {WIDTH{i_b_bit}};
  assign w_c[0] = 1'b0;

  for (genvar i = 0; i < WIDTH; i++) begin : g_fa
    assign o_sum[i]  = i_acc_hi[i] ^ w_pp[i] ^ w_c[i];
    assign w_c[i+1]  = (i_acc_hi[i] & w_pp[i]) | (w_c[i] & (i_acc_hi[i] ^ w_pp[i]));
  end

  assign o_carry = w_c[WIDTH];

endmodule

// File: rtl/seq_array_multiplier.sv
// Sequential shift-add multiplier, unsigned or two's-complement, one adder row per clock.
module seq_array_multiplier
  import seq_mult_pkg::*;
#(
  parameter int unsigned WIDTH = 4
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_ena,
  input  logic               i_start,
  input  logic               i_signed_mode,
  input  logic [WIDTH-1:0]   i_op_a,
  input  logic [WIDTH-1:0]   i_op_b,
  output logic               o_busy,
  output logic               o_done,
  output logic [2*WIDTH-1:0] o_product
);

  localparam int unsigned CntW = cnt_width(WIDTH);
  localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

  if (WIDTH < WidthMin || WIDTH > WidthMax) begin : g_bad_width
    $error("seq_array_multiplier: WIDTH out of range");
  end

  state_e               r_state, r_state_d;
  logic [WIDTH-1:0]     r_mag_a, r_mag_a_d;
  logic [WIDTH-1:0]     r_mag_b, r_mag_b_d;
  logic                 r_neg, r_neg_d;
  logic [2*WIDTH-1:0]   r_acc, r_acc_d;
  logic [CntW-1:0]      r_count, r_count_d;
  logic                 r_busy, r_busy_d;
  logic                 r_done, r_done_d;
  logic [2*WIDTH-1:0]   r_product, r_product_d;

  logic [WIDTH-1:0]     w_abs_a, w_abs_b;
  logic [WIDTH-1:0]     w_sum;
  logic                 w_carry;
  logic [2*WIDTH-1:0]   w_acc_step;

  // Most negative operand wraps to 2^(WIDTH-1), which is the correct magnitude.
  assign w_abs_a = (i_signed_mode && i_op_a[WIDTH-1]) ? -i_op_a : i_op_a;
  assign w_abs_b = (i_signed_mode && i_op_b[WIDTH-1]) ? -i_op_b : i_op_b;

  mult_add_row #(
    .WIDTH (WIDTH)
  ) u_row (
    .i_acc_hi (r_acc[2*WIDTH-1:WIDTH]),
    .i_mag_a  (r_mag_a),
    .i_b_bit  (r_mag_b[r_count]),
    .o_sum    (w_sum),
    .o_carry  (w_carry)
  );

  // Right-shifting accumulator: adding into the top half then shifting equals adding mag_a<<count.
  assign w_acc_step = {w_carry, w_sum, r_acc[WIDTH-1:1]};

  always_comb begin
    r_state_d   = r_state;
    r_mag_a_d   = r_mag_a;
    r_mag_b_d   = r_mag_b;
    r_neg_d     = r_neg;
    r_acc_d     = r_acc;
    r_count_d   = r_count;
    r_busy_d    = r_busy;
    r_done_d    = 1'b0;
    r_product_d = r_product;
    unique case (r_state)
      StIdle: begin
        if (i_start) begin
          r_mag_a_d = w_abs_a;
          r_mag_b_d = w_abs_b;
          r_neg_d   = i_signed_mode & (i_op_a[WIDTH-1] ^ i_op_b[WIDTH-1]);
          r_acc_d   = '0;
          r_count_d = '0;
          r_busy_d  = 1'b1;
          r_state_d = StRun;
        end
      end
      StRun: begin
        r_acc_d   = w_acc_step;
        r_count_d = r_count + CntW'(1);
        if (r_count == LastCnt) begin
          r_state_d = StFix;
        end
      end
      StFix: begin
        r_product_d = r_neg ? -r_acc : r_acc;
        r_done_d    = 1'b1;
        r_busy_d    = 1'b0;
        r_state_d   = StIdle;
      end
      default: r_state_d = StIdle;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state   <= StIdle;
      r_mag_a   <= '0;
      r_mag_b   <= '0;
      r_neg     <= 1'b0;
      r_acc     <= '0;
      r_count   <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_product <= '0;
    end else if (i_ena) begin
      r_state   <= r_state_d;
      r_mag_a   <= r_mag_a_d;
      r_mag_b   <= r_mag_b_d;
      r_neg     <= r_neg_d;
      r_acc     <= r_acc_d;
      r_count   <= r_count_d;
      r_busy    <= r_busy_d;
      r_done    <= r_done_d;
      r_product <= r_product_d;
    end
  end

  assign o_busy    = r_busy;
  assign o_done    = r_done;
  assign o_product = r_product;

endmodule

// File: tb/tb_seq_array_multiplier.sv
// Scoreboard bench: driver queues expected products, per-instance monitors check on done.
module tb_seq_array_multiplier;

  typedef struct {
    longint prod;
    longint cyc;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ena;
  logic       start4, sm4, start8, sm8;
  logic [3:0] a4, b4;
  logic [7:0] a8, b8;
  logic       busy4, done4, busy8, done8;
  logic [7:0] prod4;
  logic [15:0] prod8;

  longint cyc = 0;   // enabled edges
  longint rawcyc = 0;
  longint last4 = -1, last8 = -1;
  int     checks = 0;
  int     errors = 0;
  exp_t   q4[$];
  exp_t   q8[$];

  seq_array_multiplier #(.WIDTH(4)) u_dut4 (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .i_ena         (ena),
    .i_start       (start4),
    .i_signed_mode (sm4),
    .i_op_a        (a4),
    .i_op_b        (b4),
    .o_busy        (busy4),
    .o_done        (done4),
    .o_product     (prod4)
  );

  seq_array_multiplier #(.WIDTH(8)) u_dut8 (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .i_ena         (ena),
    .i_start       (start8),
    .i_signed_mode (sm8),
    .i_op_a        (a8),
    .i_op_b        (b8),
    .o_busy        (busy8),
    .o_done        (done8),
    .o_product     (prod8)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    rawcyc <= rawcyc + 1;
    if (ena) cyc <= cyc + 1;
  end

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: interpret operands as integers and reduce the true product mod 2^(2w).
  function automatic longint ref_mul(input int w, input longint a, input longint b, input bit s);
    longint va, vb, mask;
    va = a;
    vb = b;
    if (s && va >= (longint'(1) << (w - 1))) va = va - (longint'(1) << w);
    if (s && vb >= (longint'(1) << (w - 1))) vb = vb - (longint'(1) << w);
    mask = (longint'(1) << (2 * w)) - 1;
    return (va * vb) & mask;
  endfunction

  // Called just after a clock edge with the DUT idle; returns just after the accepting edge.
  task automatic issue(input bit sel, input int a, input int b, input bit s);
    exp_t e;
    if (!sel) begin
      a4 = 4'(a); b4 = 4'(b); sm4 = s; start4 = 1'b1;
    end else begin
      a8 = 8'(a); b8 = 8'(b); sm8 = s; start8 = 1'b1;
    end
    @(posedge clk); #1;
    e.cyc = cyc;
    if (!sel) begin
      e.prod = ref_mul(4, a & 15, b & 15, s);
      q4.push_back(e);
      start4 = 1'b0;
      a4 = 4'($urandom); b4 = 4'($urandom); sm4 = 1'($urandom);
      chk("busy_after_accept4", busy4, 1);
    end else begin
      e.prod = ref_mul(8, a & 255, b & 255, s);
      q8.push_back(e);
      start8 = 1'b0;
      a8 = 8'($urandom); b8 = 8'($urandom); sm8 = 1'($urandom);
      chk("busy_after_accept8", busy8, 1);
    end
  endtask

  task automatic wait_done(input bit sel);
    for (int i = 0; i < 60; i++) begin
      @(posedge clk); #1;
      if ((!sel && done4) || (sel && done8)) return;
    end
    chk("done_timeout", 0, 1);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (done4 && cyc != last4) begin
      last4 = cyc;
      if (q4.size() == 0) begin
        chk("unexpected_done4", 1, 0);
      end else begin
        e = q4.pop_front();
        chk("product4", prod4, e.prod);
        chk("latency4", cyc - e.cyc, 5);
        chk("busy_at_done4", busy4, 0);
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (done8 && cyc != last8) begin
      last8 = cyc;
      if (q8.size() == 0) begin
        chk("unexpected_done8", 1, 0);
      end else begin
        e = q8.pop_front();
        chk("product8", prod8, e.prod);
        chk("latency8", cyc - e.cyc, 9);
        chk("busy_at_done8", busy8, 0);
      end
    end
  end

  initial begin
    longint raw0;
    rst_n = 1'b0; ena = 1'b1;
    start4 = 1'b0; sm4 = 1'b0; a4 = '0; b4 = '0;
    start8 = 1'b0; sm8 = 1'b0; a8 = '0; b8 = '0;
    #12;
    chk("reset_busy4", busy4, 0);
    chk("reset_done4", done4, 0);
    chk("reset_prod4", prod4, 0);
    chk("reset_prod8", prod8, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed WIDTH=4 cases, each next start lands on the previous done cycle.
    issue(0, 15, 15, 0); wait_done(0);
    issue(0, 8, 8, 1);   wait_done(0);
    issue(0, 13, 5, 1);  wait_done(0);
    issue(0, 13, 5, 0);  wait_done(0);

    // Start while busy is ignored.
    issue(0, 3, 2, 0);
    @(posedge clk); #1;
    a4 = 4'd7; b4 = 4'd7; sm4 = 1'b0; start4 = 1'b1;
    @(posedge clk); #1;
    start4 = 1'b0;
    wait_done(0);
    issue(0, 6, 7, 1);   wait_done(0);

    // ena held low for three edges mid-RUN.
    issue(0, 9, 9, 0);
    raw0 = rawcyc;
    @(posedge clk); #1;
    ena = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    ena = 1'b1;
    wait_done(0);
    chk("ena_delay", rawcyc - raw0, 8);
    @(posedge clk); #1;

    // Asynchronous reset mid-RUN.
    issue(0, 5, 6, 1);
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("async_rst_busy", busy4, 0);
    chk("async_rst_done", done4, 0);
    chk("async_rst_prod", prod4, 0);
    q4.delete();
    #2 rst_n = 1'b1;
    repeat (10) begin @(posedge clk); #1; end
    issue(0, 5, 6, 1);   wait_done(0);

    for (int i = 0; i < 30; i++) begin
      issue(0, $urandom_range(0, 15), $urandom_range(0, 15), 1'($urandom_range(0, 1)));
      wait_done(0);
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
    end

    // WIDTH=8 corners then random sweep.
    issue(1, 8'h80, 8'h80, 1); wait_done(1);
    issue(1, 8'hFF, 8'hFF, 0); wait_done(1);
    issue(1, 8'h80, 8'h7F, 1); wait_done(1);
    issue(1, 8'hFF, 8'h01, 1); wait_done(1);
    for (int i = 0; i < 40; i++) begin
      issue(1, $urandom_range(0, 255), $urandom_range(0, 255), 1'($urandom_range(0, 1)));
      wait_done(1);
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
    end

    repeat (12) @(posedge clk);
    #1;
    chk("queue4_drained", q4.size(), 0);
    chk("queue8_drained", q8.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
